// File: rtl/shift_sched_if.sv
// Request/result bundle for the shared shift-left sequencer.
// master: the client side (drives requests, accepts results); slave: the sequencer.
interface shift_sched_if #(
  parameter int unsigned n     = 8,
  parameter int unsigned amt_n = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [n-1:0]     req0_d;
  logic [amt_n-1:0] req0_amt;
  logic             req1_valid;
  logic             req1_ready;
  logic [n-1:0]     req1_d;
  logic [amt_n-1:0] req1_amt;
  logic             res_valid;
  logic             res_ready;
  logic [n-1:0]     res;
  logic             res_id;
  logic             busy;

  modport master (
    output req0_valid, req0_d, req0_amt,
    output req1_valid, req1_d, req1_amt,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_d, req0_amt,
    input  req1_valid, req1_d, req1_amt,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res, res_id, busy
  );
endinterface

// File: rtl/shift_sched.sv
// shift_sched: round-robin sequencer in front of an iterative shift-left-logical
// accumulator. One job in flight at a time; result returned tagged with the
// requester id.
// Build option: SHIFT_SCHED_MULTIBIT_EN shifts by 2 per cycle while at least two
// positions remain (same results, fewer cycles).
module shift_sched #(
  parameter int unsigned n     = 8,
  parameter int unsigned amt_n = 3
) (
  input  logic         clk,
  input  logic         rst,
  shift_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [amt_n-1:0] CNT_ZERO = amt_n'(0);
  localparam logic [amt_n-1:0] CNT_ONE  = amt_n'(1);
`ifdef SHIFT_SCHED_MULTIBIT_EN
  localparam logic [amt_n-1:0] CNT_TWO  = amt_n'(2);
`endif

  state_t           state_q, state_d;
  logic [n-1:0]     acc_q, acc_d;
  logic [amt_n-1:0] cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             grant0_c, grant1_c;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant0_c = bus.req0_valid && (!bus.req1_valid || last_q);
    grant1_c = bus.req1_valid && (!bus.req0_valid || !last_q);
  end

  // Ready only in IDLE, and forced low while reset is asserted.
  assign bus.req0_ready = rst && (state_q == IDLE) && grant0_c;
  assign bus.req1_ready = rst && (state_q == IDLE) && grant1_c;

  // Result port is a decode of the registered state; zero when not presenting.
  assign bus.res_valid = (state_q == DONE);
  assign bus.res       = (state_q == DONE) ? acc_q : '0;
  assign bus.res_id    = (state_q == DONE) && id_q;
  assign bus.busy      = (state_q != IDLE);

  // State and datapath registers; reset makes req0 win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (grant0_c) begin
          acc_d   = bus.req0_d;
          cnt_d   = bus.req0_amt;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = (bus.req0_amt != CNT_ZERO) ? SHIFT : DONE;
        end else if (grant1_c) begin
          acc_d   = bus.req1_d;
          cnt_d   = bus.req1_amt;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = (bus.req1_amt != CNT_ZERO) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
`ifdef SHIFT_SCHED_MULTIBIT_EN
        if (cnt_q >= CNT_TWO) begin
          acc_d = acc_q << 2;
          cnt_d = cnt_q - CNT_TWO;
          if (cnt_q == CNT_TWO) state_d = DONE;
        end else begin
          acc_d   = acc_q << 1;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = DONE;
        end
`else
        acc_d = acc_q << 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = DONE;
`endif
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
